// File: rtl/shift_sched.sv
// Two-requester front end for a shared external combinational shifter:
// round-robin grant, one operation in flight, registered result held until the consumer accepts it.
module shift_sched #(
   parameter int WIDTH = 32,
   parameter int SW    = 5,
   parameter int CNTW  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_data,
   input  logic [2*SW-1:0]    req_amt,
   input  logic [1:0]         req_left,
   input  logic [1:0]         req_log,
   output logic [WIDTH-1:0]   sh_X,
   output logic [SW-1:0]      sh_S,
   output logic               sh_LEFT,
   output logic               sh_LOG,
   input  logic [WIDTH-1:0]   sh_Z,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WIDTH-1:0]   res_data,
   output logic               res_src,
   output logic [CNTW-1:0]    op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_idx_s;
   logic              gnt_s;
   logic [WIDTH-1:0]  x_q;
   logic [SW-1:0]     s_q;
   logic              left_q, log_q, src_q;
   logic [WIDTH-1:0]  res_data_q;
   logic              res_src_q;
   logic [CNTW-1:0]   op_count_q;

   // Next state, arbitration and the combinational accept strobe
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_s     = 1'b0;
      gnt_idx_s = 1'b0;
      req_ready = 2'b00;
      // last_q holds the previous winner; a tie goes to the other requester
      if (req_valid == 2'b11) begin
         gnt_idx_s = ~last_q;
      end else begin
         gnt_idx_s = req_valid[1];
      end
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gnt_s   = 1'b1;
               last_d  = gnt_idx_s;
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
      if (gnt_s && rst_n) begin
         req_ready = gnt_idx_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

   // State, operand, result and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         x_q        <= {WIDTH{1'b0}};
         s_q        <= {SW{1'b0}};
         left_q     <= 1'b0;
         log_q      <= 1'b0;
         src_q      <= 1'b0;
         res_data_q <= {WIDTH{1'b0}};
         res_src_q  <= 1'b0;
         op_count_q <= {CNTW{1'b0}};
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         if (gnt_s) begin
            x_q    <= gnt_idx_s ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
            s_q    <= gnt_idx_s ? req_amt[2*SW-1:SW] : req_amt[SW-1:0];
            left_q <= req_left[gnt_idx_s];
            log_q  <= req_log[gnt_idx_s];
            src_q  <= gnt_idx_s;
         end
         if (state_q == EXEC) begin
            res_data_q <= sh_Z;
            res_src_q  <= src_q;
         end
         if ((state_q == RESP) && res_ready) begin
            op_count_q <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign sh_X      = x_q;
   assign sh_S      = s_q;
   assign sh_LEFT   = left_q;
   assign sh_LOG    = log_q;
   assign res_valid = (state_q == RESP);
   assign res_data  = res_data_q;
   assign res_src   = res_src_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched with a behavioural model of the external shifter.
module tb_shift_sched;

   localparam int WIDTH = 32;
   localparam int SW    = 5;
   localparam int CNTW  = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_data;
   logic [2*SW-1:0]    req_amt;
   logic [1:0]         req_left;
   logic [1:0]         req_log;
   logic [WIDTH-1:0]   sh_X;
   logic [SW-1:0]      sh_S;
   logic               sh_LEFT;
   logic               sh_LOG;
   logic [WIDTH-1:0]   sh_Z;
   logic               res_valid;
   logic               res_ready;
   logic [WIDTH-1:0]   res_data;
   logic               res_src;
   logic [CNTW-1:0]    op_count;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   shift_sched #(.WIDTH(WIDTH), .SW(SW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_amt(req_amt),
      .req_left(req_left), .req_log(req_log),
      .sh_X(sh_X), .sh_S(sh_S), .sh_LEFT(sh_LEFT), .sh_LOG(sh_LOG),
      .sh_Z(sh_Z),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_src(res_src), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] x,
                                                  input logic [SW-1:0] s,
                                                  input logic left, input logic lg);
      if (left)    return x << s;
      else if (lg) return x >> s;
      else         return WIDTH'($signed(x) >>> s);
   endfunction

   assign sh_Z = ref_shift(sh_X, sh_S, sh_LEFT, sh_LOG);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT in IDLE and req_* fields already set.
   task automatic run_op(input logic [1:0] vld, input logic exp_g,
                         input logic [WIDTH-1:0] exp_res, input logic hold);
      req_valid = vld;
      #1;
      chk("grant", 64'(req_ready), exp_g ? 64'h2 : 64'h1);
      @(posedge clk); #1;
      if (!hold) begin
         req_valid = 2'b00;
         req_data  = ~req_data;
         req_amt   = ~req_amt;
         req_left  = ~req_left;
         req_log   = ~req_log;
      end
      chk("exec_ready", 64'(req_ready), 64'h0);
      chk("exec_valid", 64'(res_valid), 64'h0);
      @(posedge clk); #1;
      chk("resp_valid", 64'(res_valid), 64'h1);
      chk("resp_data", 64'(res_data), 64'(exp_res));
      chk("resp_src", 64'(res_src), 64'(exp_g));
      chk("resp_ready", 64'(req_ready), 64'h0);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      exp_cnt++;
      chk("idle_valid", 64'(res_valid), 64'h0);
      chk("op_count", 64'(op_count), 64'(exp_cnt));
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] snap;
      logic             g;

      // Reset with traffic present: nothing may be accepted
      rst_n     = 1'b0;
      req_valid = 2'b11;
      res_ready = 1'b1;
      req_data  = {32'h1234_5678, 32'h9ABC_DEF0};
      req_amt   = {5'd3, 5'd7};
      req_left  = 2'b11;
      req_log   = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_valid", 64'(res_valid), 64'h0);
      chk("rst_data", 64'(res_data), 64'h0);
      chk("rst_src", 64'(res_src), 64'h0);
      chk("rst_count", 64'(op_count), 64'h0);
      chk("rst_shx", 64'({sh_X, sh_S, sh_LEFT, sh_LOG}), 64'h0);
      req_valid = 2'b00;
      res_ready = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk); #1;

      // Both requesters valid throughout: grants alternate starting with 0
      req_data = {32'h8000_0000, 32'h8000_0000};
      req_amt  = {5'd4, 5'd4};
      req_left = 2'b00;
      req_log  = 2'b10;
      run_op(2'b11, 1'b0, 32'hF800_0000, 1'b1);
      run_op(2'b11, 1'b1, 32'h0800_0000, 1'b1);
      run_op(2'b11, 1'b0, 32'hF800_0000, 1'b1);
      run_op(2'b11, 1'b1, 32'h0800_0000, 1'b1);
      chk("rr_count4", 64'(op_count), 64'h4);

      // Single requesters, including a repeat win for requester 1
      req_data = {32'h0, 32'h0000_0001};
      req_amt  = {5'd0, 5'd31};
      req_left = 2'b01;
      req_log  = 2'b00;
      run_op(2'b01, 1'b0, 32'h8000_0000, 1'b0);
      req_data = {32'h8765_4321, 32'h0};
      req_amt  = {5'd0, 5'd0};
      req_left = 2'b00;
      req_log  = 2'b00;
      run_op(2'b10, 1'b1, 32'h8765_4321, 1'b0);
      req_left = 2'b10;
      req_amt  = {5'd0, 5'd9};
      req_data = {32'h1234_5678, 32'h0};
      run_op(2'b10, 1'b1, 32'h1234_5678, 1'b0);

      // Consumer stall in RESP; res_ready raised during EXEC must be ignored
      req_data  = {32'h0, 32'hF0F0_F0F0};
      req_amt   = {5'd0, 5'd8};
      req_left  = 2'b00;
      req_log   = 2'b01;
      req_valid = 2'b01;
      #1;
      chk("stall_grant", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      req_valid = 2'b11;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 64'(res_valid), 64'h1);
         chk("stall_data", 64'(res_data), 64'h00F0_F0F0);
         chk("stall_src", 64'(res_src), 64'h0);
         chk("stall_ready", 64'(req_ready), 64'h0);
         chk("stall_count", 64'(op_count), 64'(exp_cnt));
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      req_valid = 2'b00;
      exp_cnt++;
      chk("stall_release_count", 64'(op_count), 64'(exp_cnt));
      chk("stall_release_valid", 64'(res_valid), 64'h0);
      @(posedge clk); #1;

      // Every amount with every left/log combination on random operands
      for (int a = 0; a < 32; a++) begin
         for (int k = 0; k < 4; k++) begin
            d = $urandom;
            g = 1'((a + k) % 2);
            if (g) begin
               req_data = {d, ~d};
               req_amt  = {5'(a), 5'(31 - a)};
            end else begin
               req_data = {~d, d};
               req_amt  = {5'(31 - a), 5'(a)};
            end
            req_left = {2{k[1]}};
            req_log  = {2{k[0]}};
            run_op(g ? 2'b10 : 2'b01, g, ref_shift(d, 5'(a), k[1], k[0]), 1'b0);
         end
      end

      // Reset during EXEC discards the operation
      snap      = 32'hAAAA_5555;
      req_data  = {snap, 32'h0};
      req_amt   = {5'd3, 5'd0};
      req_left  = 2'b10;
      req_log   = 2'b00;
      req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b00;
      rst_n     = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(res_valid), 64'h0);
      chk("mid_rst_data", 64'(res_data), 64'h0);
      chk("mid_rst_src", 64'(res_src), 64'h0);
      chk("mid_rst_count", 64'(op_count), 64'h0);
      chk("mid_rst_shx", 64'({sh_X, sh_S, sh_LEFT, sh_LOG}), 64'h0);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      exp_cnt = 0;
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(res_valid), 64'h0);
      req_data = {snap, 32'h0000_00FF};
      req_amt  = {5'd3, 5'd4};
      req_left = 2'b11;
      req_log  = 2'b00;
      run_op(2'b11, 1'b0, 32'h0000_0FF0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter WIDTH, 32, datapath width of operands and results.
REQ-002 Parameter SW, 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Parameter CNTW, 16, width of the completed-operation counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-007 req_ready  out  2  per-requester accept strobe.
REQ-008 req_data  in  2*WIDTH  operand; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 req_amt  in  2*SW  shift amount; requester i in bits [i*SW +: SW].
REQ-010 req_left  in  2  1 = shift left, 0 = shift right.
REQ-011 req_log  in  2  1 = logical, 0 = arithmetic (right shifts only; ignored for left).
REQ-012 sh_X, sh_S, sh_LEFT, sh_LOG  out  WIDTH/SW/1/1  operand and controls to the shared combinational shifter.
REQ-013 sh_Z  in  WIDTH  shifter result.
REQ-014 res_valid  out  1  result valid.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 res_data  out  WIDTH  registered shift result.
REQ-017 res_src  out  1  index of requester that issued res_data.
REQ-018 op_count  out  CNTW  number of results consumed since reset.

Function
REQ-019 The block SHALL implement states IDLE, EXEC, RESP.
REQ-020 IDLE: if any req_valid bit is set, the block SHALL grant one requester, assert its req_ready bit in that same cycle (combinationally), latch its data, amount, left and log into operand registers at the edge, and go to EXEC.
REQ-021 req_ready SHALL be 0 in EXEC and RESP, and SHALL never have both bits set.
REQ-022 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer.
REQ-023 The last-grant pointer SHALL update only on a grant; after reset requester 0 wins the first tie.
REQ-024 sh_X, sh_S, sh_LEFT, sh_LOG SHALL be driven from the operand registers at all times (not from req_* directly).
REQ-025 EXEC: lasts exactly one cycle; at its closing edge the block SHALL capture sh_Z into res_data and the granted index into res_src, then go to RESP.
REQ-026 RESP: res_valid SHALL be 1; res_data and res_src SHALL be held stable until res_ready is sampled high.
REQ-027 In RESP with res_ready=1, the block SHALL go to IDLE and increment op_count at that edge; no new request is accepted in that cycle.
REQ-028 Latency: grant at edge N, res_valid high from edge N+2; minimum issue interval 3 cycles.
REQ-029 op_count SHALL wrap from 2^CNTW-1 to 0.
REQ-030 req_valid deasserting while not ready SHALL have no effect; req_* changes after grant SHALL not affect the in-flight operation.
REQ-031 res_ready high in IDLE or EXEC SHALL be ignored.

Reset
REQ-032 While rst_n=0: state IDLE, req_ready=0, res_valid=0, res_data=0, res_src=0, op_count=0, operand registers 0 (sh_X=0, sh_S=0, sh_LEFT=0, sh_LOG=0), pointer so requester 0 wins the first tie.
REQ-033 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing a result or counting it.

Verification
REQ-034 Req0 data 0x80000000, amt 4, left=0, log=0 -> res_data 0xF8000000, res_src 0, res_valid two edges after grant.
REQ-035 Req1 data 0x80000000, amt 4, log=1 -> 0x08000000; req0 data 0x00000001, amt 31, left=1 -> 0x80000000; amt 0 -> data unchanged.
REQ-036 Both requesters valid continuously, res_ready=1 -> grants 0,1,0,1, res_src alternates, op_count=4 after four results.
REQ-037 res_ready held 0 for 5 cycles in RESP -> res_valid, res_data, res_src stable, req_ready=0 throughout; op_count increments once on release.
REQ-038 rst_n pulsed low during EXEC -> all outputs return to reset values immediately; op_count=0; next request serviced normally.
REQ-039 Random operands across all amounts 0..31 and all left/log combinations -> res_data matches the reference <<, >>, >>> result every time.
